stream_unpacker: RTL and testbench
==================================

# stream_unpacker

- Drains a wide valid/ready word stream, such as the read side of our FIFO, and emits it as a narrow beat stream, least-significant slice first.
- Holds one word and walks a beat index across it.
- Sustains one output beat per cycle, including across word boundaries, with no bubble.
- Sits between the FIFO read port and narrow consumers (byte-serial transmitters, narrow bus masters).

## Interface

Parameters:
- C_DATA_WIDTH, 64, input word width; must be an integer multiple of C_OUT_WIDTH.
- C_OUT_WIDTH, 8, output beat width.
- Derived RATIO = C_DATA_WIDTH / C_OUT_WIDTH; must be ≥ 2. Beat index width is $clog2(RATIO).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-low reset.
- s_valid  input  1  input word valid; connects to FIFO read_valid.
- s_ready  output  1  block accepts a word this cycle; connects to FIFO read_ready.
- s_data  input  C_DATA_WIDTH  input word; connects to FIFO read_data.
- s_last  input  1  word is the final word of a frame; sampled with s_data.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts beat.
- m_data  output  C_OUT_WIDTH  current beat.
- m_last  output  1  final beat of a word that carried s_last.
- idle  output  1  no word held.

## Operation

- State:
  - full_q: word held.
  - word_q: C_DATA_WIDTH data.
  - last_q: captured s_last.
  - idx_q: beat index, 0..RATIO-1.
- Derived signals:
  - s_fire = s_valid && s_ready.
  - m_fire = m_valid && m_ready.
  - end_beat = (idx_q == RATIO-1).
- m_valid = full_q.
- idle = !full_q.
- m_data = word_q[idx_q*C_OUT_WIDTH +: C_OUT_WIDTH]; slice 0 (LSBs) goes out first.
- m_last = full_q && last_q && end_beat.
- s_ready = !full_q || (m_fire && end_beat). The same-cycle refill path is required; holding s_ready low until a free cycle is not acceptable.
- Two states:
  - EMPTY (full_q=0):
    - s_fire → HOLD; load word_q and last_q; idx_q=0.
  - HOLD (full_q=1):
    - m_fire && !end_beat → idx_q += 1.
    - m_fire && end_beat && s_fire → stay HOLD; reload word_q and last_q; idx_q=0.
    - m_fire && end_beat && !s_fire → EMPTY; idx_q=0.
    - !m_fire → no state change.
- Stability under backpressure: while m_valid && !m_ready, m_data and m_last do not change.
- s_data is ignored unless s_fire.
- Reset (resetn=0 at an edge) sets:
  - full_q=0, last_q=0, idx_q=0.
  - word_q is don't-care.
  - Resulting outputs: m_valid=0, m_last=0, idle=1, s_ready=1.
- Reset mid-word discards the held word and remaining beats. No s_fire or m_fire takes effect on a reset edge.
- idx_q never exceeds RATIO-1, and wraps only through the end_beat transitions.

## Timing

- Latency: word accepted at edge N → beat 0 on m_data in cycle N+1 (registered, one cycle).
- Throughput: with s_valid and m_ready held high, exactly one beat per cycle. RATIO words produce RATIO×RATIO beats in RATIO×RATIO consecutive cycles.
- s_ready combinationally depends on m_ready. m_valid, m_data and m_last are pure register outputs.
- No combinational path exists from s_valid or s_data to any m_* output.
- After reset release, the first s_fire can occur in the first cycle with resetn=1.

## Test plan

- Single word, RATIO=8:
  - Stimulus: s_data=0x0807060504030201, s_last=1, m_ready=1.
  - Response: m_data 01,02,…,08 in 8 consecutive cycles starting 1 cycle after s_fire. m_last=1 only on 08. idle=1 afterwards.
- Back-to-back words:
  - Stimulus: 0x0F0E0D0C0B0A0908 (s_last=0) then 0x1716151413121110 (s_last=1), s_valid and m_ready continuously high.
  - Response: 16 beats 08..17 with no gap. s_ready pulses high in the cycle of beat 0F. m_last only on 17.
- Backpressure:
  - Stimulus: m_ready=0 for 3 cycles at beat index 3 of 0x0807060504030201.
  - Response: m_data=04 and m_valid=1 held for those 3 cycles. s_ready=0. The remaining beats resume in order.
- Upstream starvation:
  - Stimulus: s_valid low for 5 cycles between two words.
  - Response: m_valid=0 and idle=1 during the gap. No beats are duplicated or lost.
- Reset mid-word:
  - Stimulus: resetn=0 for 1 cycle after beat 02 of 0x0807060504030201.
  - Response: next cycle m_valid=0, m_last=0, s_ready=1, idle=1. The next word starts at its beat 0.
- Reset value check:
  - Stimulus: hold resetn=0 with s_valid=1 and random s_data.
  - Response: m_valid stays 0. No word is captured.

Source files
------------

// File: rtl/stream_unpacker_if.sv
// Generic valid/ready stream bundle carrying a data word and an end-of-frame flag.
// Master drives valid/data/last and samples ready; slave does the reverse.
interface stream_if #(
    parameter int C_WIDTH = 8
);
    logic               valid;
    logic               ready;
    logic [C_WIDTH-1:0] data;
    logic               last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/stream_unpacker.sv
// Splits wide words from s into narrow beats on m, least-significant slice first.
// Latency: one cycle from word accept to beat 0; one beat per cycle sustained.
// Backpressure: m beats hold while m.ready is low; s.ready refills in the last-beat cycle.
module stream_unpacker #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_OUT_WIDTH  = 8
) (
    input  logic      clk,
    input  logic      resetn,
    stream_if.slave   s,
    stream_if.master  m,
    output logic      idle
);
    localparam int RATIO = C_DATA_WIDTH / C_OUT_WIDTH;
    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                  state_q;
    logic [C_DATA_WIDTH-1:0] word_q;
    logic                    last_q;
    logic [IDX_W-1:0]        idx_q;

    logic full_q;
    logic end_beat;
    logic s_fire;
    logic m_fire;

    assign full_q   = (state_q == HOLD);
    assign end_beat = (idx_q == LAST_IDX);
    assign m_fire   = m.valid && m.ready;
    assign s_fire   = s.valid && s.ready;

    // Refill in the same cycle the final beat leaves, so words chain with no bubble.
    assign s.ready  = !full_q || (m_fire && end_beat);

    // word_q is shifted down each beat, so the current slice always sits in the
    // low bits and m.data is a straight register output rather than a wide mux.
    assign m.valid  = full_q;
    assign m.data   = word_q[C_OUT_WIDTH-1:0];
    assign m.last   = full_q && last_q && end_beat;
    assign idle     = !full_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= EMPTY;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (s_fire) begin
                        state_q <= HOLD;
                        word_q  <= s.data;
                        last_q  <= s.last;
                        idx_q   <= '0;
                    end
                end
                HOLD: begin
                    if (m_fire) begin
                        if (!end_beat) begin
                            idx_q  <= idx_q + 1'b1;
                            word_q <= word_q >> C_OUT_WIDTH;
                        end else if (s_fire) begin
                            word_q <= s.data;
                            last_q <= s.last;
                            idx_q  <= '0;
                        end else begin
                            state_q <= EMPTY;
                            idx_q   <= '0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stream_unpacker.sv
// Randomized bench for stream_unpacker: accepted words expand into expected beats
// in a queue; an independent monitor pops and compares every presented beat.
module tb_stream_unpacker;
    localparam int DW    = 64;
    localparam int OW    = 8;
    localparam int R     = DW / OW;
    localparam int MAIN  = 700;
    localparam int TOTAL = MAIN + 2 * R + 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic idle;

    stream_if #(.C_WIDTH(DW)) s_if ();
    stream_if #(.C_WIDTH(OW)) m_if ();

    stream_unpacker #(
        .C_DATA_WIDTH (DW),
        .C_OUT_WIDTH  (OW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .s      (s_if.slave),
        .m      (m_if.master),
        .idle   (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: mid-cycle, compare DUT outputs with the expected beat queue.
    initial begin
        forever begin
            @(negedge clk);
            begin
                int n;
                n = exp_q.size();
                check("m_valid", 64'(m_if.valid), 64'(n != 0));
                check("idle",    64'(idle),       64'(n == 0));
                check("s_ready", 64'(s_if.ready), 64'((n == 0) || (n == 1 && m_if.ready)));
                if (n == 0) begin
                    check("m_last_idle", 64'(m_if.last), 64'd0);
                end else begin
                    check("m_data", 64'(m_if.data), 64'(exp_q[0].d));
                    check("m_last", 64'(m_if.last), 64'(exp_q[0].l));
                    if (m_if.valid && m_if.ready)
                        void'(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus: directed test-plan words first, then randomized phases.
    initial begin
        logic [DW-1:0] dir_w [4];
        logic          dir_l [4];
        logic [DW-1:0] pd;
        logic          pl;
        logic          acc;
        int            dir_i;
        int            pv;
        int            pr;
        beat_t         b;

        dir_w[0] = 64'h0807060504030201; dir_l[0] = 1'b1;
        dir_w[1] = 64'h0F0E0D0C0B0A0908; dir_l[1] = 1'b0;
        dir_w[2] = 64'h1716151413121110; dir_l[2] = 1'b1;
        dir_w[3] = 64'h0807060504030201; dir_l[3] = 1'b1;
        dir_i = 0;
        pd    = dir_w[0];
        pl    = dir_l[0];
        acc   = 1'b0;

        resetn      = 1'b0;
        s_if.valid  = 1'b1;
        s_if.data   = {$urandom, $urandom};
        s_if.last   = 1'b1;
        m_if.ready  = 1'b1;

        for (int c = 0; c < TOTAL; c++) begin
            @(posedge clk);
            if (!resetn) begin
                exp_q.delete();
            end else if (acc) begin
                // Reference: beat i is bits [i*OW +: OW]; last only on the final beat.
                for (int i = 0; i < R; i++) begin
                    b.d = OW'(pd >> (i * OW));
                    b.l = pl && (i == R - 1);
                    exp_q.push_back(b);
                end
                dir_i++;
                if (dir_i < 4) begin
                    pd = dir_w[dir_i];
                    pl = dir_l[dir_i];
                end else begin
                    pd = {$urandom, $urandom};
                    pl = 1'($urandom_range(0, 1));
                end
            end
            #1;
            if (c < 4) begin
                // Held in reset with a valid word presented: nothing may be captured.
                resetn     = 1'b0;
                s_if.valid = 1'b1;
                s_if.data  = {$urandom, $urandom};
                m_if.ready = 1'b1;
            end else if (c < 80) begin
                resetn     = !(c == 60);
                s_if.valid = !(c >= 40 && c < 45);
                m_if.ready = !(c >= 12 && c < 15);
                s_if.data  = s_if.valid ? pd : {$urandom, $urandom};
            end else if (c < MAIN) begin
                case (((c - 80) / 155) % 4)
                    0:       begin pv = 100; pr = 100; end
                    1:       begin pv = 100; pr = 35;  end
                    2:       begin pv = 30;  pr = 100; end
                    default: begin pv = 60;  pr = 60;  end
                endcase
                resetn     = ($urandom_range(0, 119) != 0);
                s_if.valid = ($urandom_range(0, 99) < pv);
                m_if.ready = ($urandom_range(0, 99) < pr);
                s_if.data  = s_if.valid ? pd : {$urandom, $urandom};
            end else begin
                resetn     = 1'b1;
                s_if.valid = 1'b0;
                m_if.ready = 1'b1;
                s_if.data  = {$urandom, $urandom};
            end
            s_if.last = pl;
            @(negedge clk);
            acc = s_if.valid && s_if.ready;
        end

        @(negedge clk);
        check("drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
